// File: rtl/lpc_io_arbiter.sv
// Bridges the lpc_periph data-provider handshake to NUM_TGT register-bank targets.
// It decodes the address, strobes the selected target, and returns read data or 0xFF on a miss or timeout.
module lpc_io_arbiter #(
   parameter int unsigned                NUM_TGT  = 4,
   parameter logic [16*NUM_TGT-1:0]      TGT_BASE = {16'h0080, 16'h0060, 16'h03F8, 16'h002E},
   parameter logic [16*NUM_TGT-1:0]      TGT_MASK = {16'hFFFF, 16'hFFFB, 16'hFFF8, 16'hFFFE},
   parameter int unsigned                TIMEOUT  = 255
) (
   input  logic                   clk_i,
   input  logic                   nrst_i,
   input  logic [15:0]            lpc_addr_i,
   input  logic                   lpc_data_wr_i,
   input  logic                   lpc_data_req_i,
   input  logic [7:0]             lpc_wdata_i,
   output logic                   lpc_wr_done_o,
   output logic                   lpc_data_rd_o,
   output logic [7:0]             lpc_rdata_o,
   output logic                   lpc_rdata_oe_o,
   output logic [15:0]            tgt_addr_o,
   output logic [7:0]             tgt_wdata_o,
   output logic [NUM_TGT-1:0]     tgt_wr_o,
   output logic [NUM_TGT-1:0]     tgt_rd_o,
   input  logic [NUM_TGT-1:0]     tgt_ack_i,
   input  logic [8*NUM_TGT-1:0]   tgt_rdata_i,
   output logic                   timeout_o
);

   localparam int unsigned SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DECODE, WAIT, DONE} state_t;

   state_t              state, state_n;
   logic                dir, dir_n;
   logic [15:0]         addr, addr_n;
   logic [7:0]          wdata, wdata_n;
   logic [SW-1:0]       sel, sel_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                wr_done, wr_done_n;
   logic                data_rd, data_rd_n;
   logic [7:0]          rdata, rdata_n;
   logic [NUM_TGT-1:0]  tgt_wr, tgt_wr_n;
   logic [NUM_TGT-1:0]  tgt_rd, tgt_rd_n;
   logic                timeout, timeout_n;
   logic                hit_any;
   logic [SW-1:0]       hit_sel;
   logic                req_live;
   logic [7:0]          ack_data;

   // Lowest-index hit wins when windows overlap.
   always_comb begin
      hit_any = 1'b0;
      hit_sel = '0;
      for (int unsigned i = 0; i < NUM_TGT; i++) begin
         if (!hit_any && ((addr & TGT_MASK[16*i +: 16]) == TGT_BASE[16*i +: 16])) begin
            hit_any = 1'b1;
            hit_sel = SW'(i);
         end
      end
   end

   assign req_live = dir ? lpc_data_wr_i : lpc_data_req_i;
   assign ack_data = tgt_rdata_i[8*int'(sel) +: 8];

   always_comb begin
      state_n   = state;
      dir_n     = dir;
      addr_n    = addr;
      wdata_n   = wdata;
      sel_n     = sel;
      cnt_n     = '0;
      wr_done_n = wr_done;
      data_rd_n = data_rd;
      rdata_n   = rdata;
      tgt_wr_n  = '0;
      tgt_rd_n  = '0;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            if (lpc_data_wr_i || lpc_data_req_i) begin
               state_n = DECODE;
               dir_n   = lpc_data_wr_i;
               addr_n  = lpc_addr_i;
               wdata_n = lpc_wdata_i;
            end
         end
         DECODE: begin
            if (!req_live) begin
               state_n = IDLE;
            end else if (hit_any) begin
               state_n = WAIT;
               sel_n   = hit_sel;
               if (dir) tgt_wr_n[hit_sel] = 1'b1;
               else     tgt_rd_n[hit_sel] = 1'b1;
            end else begin
               state_n   = DONE;
               wr_done_n = dir;
               data_rd_n = !dir;
               rdata_n   = dir ? 8'h00 : 8'hFF;
            end
         end
         WAIT: begin
            cnt_n = cnt + 1'b1;
            // An ack in the expiry cycle takes priority over the timeout.
            if (!req_live) begin
               state_n = IDLE;
            end else if (tgt_ack_i[sel]) begin
               state_n   = DONE;
               wr_done_n = dir;
               data_rd_n = !dir;
               rdata_n   = dir ? 8'h00 : ack_data;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_n   = DONE;
               wr_done_n = dir;
               data_rd_n = !dir;
               rdata_n   = dir ? 8'h00 : 8'hFF;
               timeout_n = 1'b1;
            end
         end
         DONE: begin
            if (!req_live) begin
               state_n   = IDLE;
               wr_done_n = 1'b0;
               data_rd_n = 1'b0;
               rdata_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state   <= IDLE;
         dir     <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
         sel     <= '0;
         cnt     <= '0;
         wr_done <= 1'b0;
         data_rd <= 1'b0;
         rdata   <= '0;
         tgt_wr  <= '0;
         tgt_rd  <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         dir     <= dir_n;
         addr    <= addr_n;
         wdata   <= wdata_n;
         sel     <= sel_n;
         cnt     <= cnt_n;
         wr_done <= wr_done_n;
         data_rd <= data_rd_n;
         rdata   <= rdata_n;
         tgt_wr  <= tgt_wr_n;
         tgt_rd  <= tgt_rd_n;
         timeout <= timeout_n;
      end
   end

   assign lpc_wr_done_o  = wr_done;
   assign lpc_data_rd_o  = data_rd;
   assign lpc_rdata_oe_o = data_rd;
   assign lpc_rdata_o    = rdata;
   assign tgt_addr_o     = addr;
   assign tgt_wdata_o    = wdata;
   assign tgt_wr_o       = tgt_wr;
   assign tgt_rd_o       = tgt_rd;
   assign timeout_o      = timeout;

endmodule

// File: tb/tb_lpc_io_arbiter.sv
// Directed bench for lpc_io_arbiter: hand-computed expectations for writes, reads, misses,
// timeouts, aborts, reset during a transaction and lowest-index decode.
module tb_lpc_io_arbiter;

   logic        clk = 1'b0;
   logic        nrst;
   logic [15:0] lpc_addr;
   logic        lpc_data_wr;
   logic        lpc_data_req;
   logic [7:0]  lpc_wdata;
   logic        lpc_wr_done;
   logic        lpc_data_rd;
   logic [7:0]  lpc_rdata;
   logic        lpc_rdata_oe;
   logic [15:0] tgt_addr;
   logic [7:0]  tgt_wdata;
   logic [3:0]  tgt_wr;
   logic [3:0]  tgt_rd;
   logic [3:0]  tgt_ack;
   logic [31:0] tgt_rdata;
   logic        timeout;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   lpc_io_arbiter #(
      .NUM_TGT (4),
      .TIMEOUT (255)
   ) dut (
      .clk_i          (clk),
      .nrst_i         (nrst),
      .lpc_addr_i     (lpc_addr),
      .lpc_data_wr_i  (lpc_data_wr),
      .lpc_data_req_i (lpc_data_req),
      .lpc_wdata_i    (lpc_wdata),
      .lpc_wr_done_o  (lpc_wr_done),
      .lpc_data_rd_o  (lpc_data_rd),
      .lpc_rdata_o    (lpc_rdata),
      .lpc_rdata_oe_o (lpc_rdata_oe),
      .tgt_addr_o     (tgt_addr),
      .tgt_wdata_o    (tgt_wdata),
      .tgt_wr_o       (tgt_wr),
      .tgt_rd_o       (tgt_rd),
      .tgt_ack_i      (tgt_ack),
      .tgt_rdata_i    (tgt_rdata),
      .timeout_o      (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " wr_done"}, 32'(lpc_wr_done), 32'h0);
      check({tag, " data_rd"}, 32'(lpc_data_rd), 32'h0);
      check({tag, " rdata_oe"}, 32'(lpc_rdata_oe), 32'h0);
      check({tag, " rdata"}, 32'(lpc_rdata), 32'h0);
      check({tag, " tgt_wr"}, 32'(tgt_wr), 32'h0);
      check({tag, " tgt_rd"}, 32'(tgt_rd), 32'h0);
      check({tag, " timeout"}, 32'(timeout), 32'h0);
      check({tag, " tgt_addr"}, 32'(tgt_addr), 32'h0);
      check({tag, " tgt_wdata"}, 32'(tgt_wdata), 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nrst = 1'b0; lpc_addr = '0; lpc_data_wr = 1'b0; lpc_data_req = 1'b0;
      lpc_wdata = '0; tgt_ack = '0; tgt_rdata = 32'h11C3_2233;
      tick(2);
      check_idle_outputs("reset");
      nrst = 1'b1;
      tick(2);

      // 1: write 0x5A to 0x0080 -> target 3, ack three cycles after the strobe
      lpc_addr = 16'h0080; lpc_wdata = 8'h5A; lpc_data_wr = 1'b1;
      tick(1);
      check("t1 no early strobe", 32'(tgt_wr), 32'h0);
      tick(1);
      check("t1 strobe", 32'(tgt_wr), 32'h8);
      check("t1 wdata", 32'(tgt_wdata), 32'h5A);
      check("t1 addr", 32'(tgt_addr), 32'h0080);
      tick(1);
      check("t1 strobe one cycle", 32'(tgt_wr), 32'h0);
      tick(2);
      tgt_ack = 4'b1000;
      check("t1 done before ack", 32'(lpc_wr_done), 32'h0);
      tick(1);
      tgt_ack = '0;
      check("t1 done", 32'(lpc_wr_done), 32'h1);
      check("t1 no rd", 32'(lpc_data_rd), 32'h0);
      tick(1);
      check("t1 done held", 32'(lpc_wr_done), 32'h1);
      lpc_data_wr = 1'b0;
      tick(1);
      check("t1 done drop", 32'(lpc_wr_done), 32'h0);
      tick(1);

      // 2: read 0x0064 -> target 2; a stray ack from target 0 is ignored
      lpc_addr = 16'h0064; lpc_data_req = 1'b1;
      tick(2);
      check("t2 strobe", 32'(tgt_rd), 32'h4);
      check("t2 no wr strobe", 32'(tgt_wr), 32'h0);
      tgt_ack = 4'b0001;
      tick(1);
      check("t2 foreign ack ignored", 32'(lpc_data_rd), 32'h0);
      tgt_ack = 4'b0100;
      tick(1);
      tgt_ack = '0; tgt_rdata = 32'h0;
      check("t2 data_rd", 32'(lpc_data_rd), 32'h1);
      check("t2 oe", 32'(lpc_rdata_oe), 32'h1);
      check("t2 rdata", 32'(lpc_rdata), 32'hC3);
      tick(1);
      check("t2 rdata held", 32'(lpc_rdata), 32'hC3);
      lpc_data_req = 1'b0; tgt_rdata = 32'h11C3_2233;
      tick(1);
      check("t2 rd drop", 32'(lpc_data_rd), 32'h0);
      check("t2 oe drop", 32'(lpc_rdata_oe), 32'h0);
      tick(1);

      // 3: unmapped read 0x0300
      lpc_addr = 16'h0300; lpc_data_req = 1'b1;
      tick(1);
      check("t3 rd early", 32'(lpc_data_rd), 32'h0);
      tick(1);
      check("t3 data_rd", 32'(lpc_data_rd), 32'h1);
      check("t3 rdata", 32'(lpc_rdata), 32'hFF);
      check("t3 no strobe", 32'(tgt_rd), 32'h0);
      check("t3 no timeout", 32'(timeout), 32'h0);
      lpc_data_req = 1'b0;
      tick(2);

      // write and read both pending: the write wins
      lpc_addr = 16'h0060; lpc_wdata = 8'h3C; lpc_data_wr = 1'b1; lpc_data_req = 1'b1;
      tick(2);
      check("wr-wins wr strobe", 32'(tgt_wr), 32'h4);
      check("wr-wins rd strobe", 32'(tgt_rd), 32'h0);
      tgt_ack = 4'b0100;
      tick(1);
      tgt_ack = '0;
      check("wr-wins done", 32'(lpc_wr_done), 32'h1);
      check("wr-wins no rd", 32'(lpc_data_rd), 32'h0);
      lpc_data_wr = 1'b0; lpc_data_req = 1'b0;
      tick(2);

      // 4: read 0x03FA with no ack -> timeout 255 cycles after WAIT entry
      lpc_addr = 16'h03FA; lpc_data_req = 1'b1;
      tick(2);
      check("t4 strobe", 32'(tgt_rd), 32'h2);
      tick(254);
      check("t4 no early timeout", 32'(timeout), 32'h0);
      check("t4 no early rd", 32'(lpc_data_rd), 32'h0);
      tick(1);
      check("t4 timeout", 32'(timeout), 32'h1);
      check("t4 data_rd", 32'(lpc_data_rd), 32'h1);
      check("t4 rdata", 32'(lpc_rdata), 32'hFF);
      tick(1);
      check("t4 timeout pulse", 32'(timeout), 32'h0);
      check("t4 rd held", 32'(lpc_data_rd), 32'h1);
      lpc_data_req = 1'b0;
      tick(2);

      // ack landing in the expiry cycle wins over the timeout
      lpc_addr = 16'h03F9; lpc_data_req = 1'b1;
      tick(2);
      check("exp strobe", 32'(tgt_rd), 32'h2);
      tick(254);
      tgt_ack = 4'b0010;
      tick(1);
      tgt_ack = '0;
      check("exp no timeout", 32'(timeout), 32'h0);
      check("exp data_rd", 32'(lpc_data_rd), 32'h1);
      check("exp rdata", 32'(lpc_rdata), 32'h22);
      lpc_data_req = 1'b0;
      tick(2);

      // 5: abort mid-WAIT, late ack ignored, then a normal write
      lpc_addr = 16'h0080; lpc_data_req = 1'b1;
      tick(2);
      check("t5 strobe", 32'(tgt_rd), 32'h8);
      tick(1);
      lpc_data_req = 1'b0;
      tick(1);
      tgt_ack = 4'b1000;
      tick(1);
      tgt_ack = '0;
      check("t5 no rd", 32'(lpc_data_rd), 32'h0);
      tick(1);
      check("t5 no rd later", 32'(lpc_data_rd), 32'h0);
      check("t5 no oe", 32'(lpc_rdata_oe), 32'h0);
      lpc_addr = 16'h002E; lpc_wdata = 8'h77; lpc_data_wr = 1'b1;
      tick(2);
      check("t5 next strobe", 32'(tgt_wr), 32'h1);
      check("t5 next wdata", 32'(tgt_wdata), 32'h77);
      tgt_ack = 4'b0001;
      tick(1);
      tgt_ack = '0;
      check("t5 next done", 32'(lpc_wr_done), 32'h1);
      lpc_data_wr = 1'b0;
      tick(1);
      check("t5 next done drop", 32'(lpc_wr_done), 32'h0);
      tick(1);

      // 6: 0x002F selects target 0; reset asserted during WAIT
      lpc_addr = 16'h002F; lpc_data_req = 1'b1;
      tick(2);
      check("t6 strobe t0", 32'(tgt_rd), 32'h1);
      check("t6 addr", 32'(tgt_addr), 32'h002F);
      tick(1);
      nrst = 1'b0;
      #1;
      check_idle_outputs("t6 reset");
      lpc_data_req = 1'b0;
      tick(1);
      nrst = 1'b1;
      tick(1);
      lpc_addr = 16'h0060; lpc_data_req = 1'b1;
      tick(2);
      check("t6 strobe t2", 32'(tgt_rd), 32'h4);
      tgt_ack = 4'b0100;
      tick(1);
      tgt_ack = '0;
      check("t6 data_rd", 32'(lpc_data_rd), 32'h1);
      check("t6 rdata", 32'(lpc_rdata), 32'hC3);
      lpc_data_req = 1'b0;
      tick(1);
      check("t6 rd drop", 32'(lpc_data_rd), 32'h0);
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
